// File: rtl/ibex_obi_wb_bridge.sv
// ibex_obi_wb_bridge
//
// Bridges the Ibex LSU data port (OBI-style req/gnt/rvalid) onto a classic
// single-master Wishbone B4 bus. Only one transaction is outstanding at a time.
// A new request can be granted in the same cycle as the previous response,
// so back-to-back accesses cost two cycles each with zero-wait slaves.
//
// Optional build macro: IBEX_OBI_WB_TIMEOUT_EN
//   When defined, a BUS cycle that sees no ack/err for TIMEOUT_CYCLES clocks
//   is terminated locally and reported to the LSU as an error response.
//   When undefined, the bridge waits indefinitely for ack/err.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   data_req_i / data_gnt_o   LSU request, combinational grant
//   data_addr_i, data_we_i,
//   data_be_i, data_wdata_i   LSU request payload
//   data_rvalid_o             one-cycle response pulse
//   data_err_o, data_rdata_o  response payload, held until the next response
//   wb_cyc_o, wb_stb_o        Wishbone cycle/strobe (registered)
//   wb_we_o, wb_sel_o,
//   wb_adr_o, wb_dat_o        Wishbone request payload, stable during a cycle
//   wb_dat_i, wb_ack_i,
//   wb_err_i                  Wishbone response
//
// State | meaning
// IDLE  | no transaction in flight, grant allowed
// BUS   | Wishbone cycle active, waiting for ack/err (or timeout)
// RESP  | response presented on data_rvalid_o, grant allowed

module ibex_obi_wb_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,

   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   gnt;
   logic   bus_done;
   logic   timeout_hit;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   assign gnt      = data_req_i & ((state_q == IDLE) | (state_q == RESP)) & ~rst_i;
   assign bus_done = wb_ack_i | wb_err_i;

`ifdef IBEX_OBI_WB_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
      end else if (gnt) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == BUS) && !bus_done) begin
         tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
   end

   // Fires in the last allowed BUS cycle so cyc/stb stay high exactly
   // TIMEOUT_CYCLES clocks; a real ack/err in that same cycle takes priority.
   assign timeout_hit = (state_q == BUS) && !bus_done &&
                        (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt) state_d = BUS;
         BUS:     if (bus_done || timeout_hit) state_d = RESP;
         RESP:    state_d = gnt ? BUS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign data_gnt_o    = gnt;
   assign wb_cyc_o      = (state_q == BUS);
   assign wb_stb_o      = (state_q == BUS);
   assign data_rvalid_o = (state_q == RESP);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_we_o      <= 1'b0;
         wb_sel_o     <= '0;
         wb_adr_o     <= '0;
         wb_dat_o     <= '0;
         data_err_o   <= 1'b0;
         data_rdata_o <= '0;
      end else begin
         if (gnt) begin
            wb_adr_o <= {data_addr_i[31:2], 2'b00};
            wb_we_o  <= data_we_i;
            wb_sel_o <= data_be_i;
            wb_dat_o <= data_wdata_i;
         end
         if (state_q == BUS) begin
            if (bus_done) begin
               // err wins over a simultaneous ack; only clean reads return data
               data_err_o   <= wb_err_i;
               data_rdata_o <= (!wb_we_o && !wb_err_i) ? wb_dat_i : 32'h0;
            end else if (timeout_hit) begin
               data_err_o   <= 1'b1;
               data_rdata_o <= 32'h0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ibex_obi_wb_bridge.sv
module tb_ibex_obi_wb_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   int checks   = 0;
   int failures = 0;

   ibex_obi_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_err_o    (data_err_o),
      .data_addr_i   (data_addr_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_wdata_i  (data_wdata_i),
      .data_rdata_o  (data_rdata_o),
      .wb_cyc_o      (wb_cyc_o),
      .wb_stb_o      (wb_stb_o),
      .wb_we_o       (wb_we_o),
      .wb_sel_o      (wb_sel_o),
      .wb_adr_o      (wb_adr_o),
      .wb_dat_o      (wb_dat_o),
      .wb_dat_i      (wb_dat_i),
      .wb_ack_i      (wb_ack_i),
      .wb_err_i      (wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic request(input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata);
      data_req_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
   endtask

   initial begin
      int hi_cnt;
      rst_i        = 1'b1;
      data_req_i   = 1'b1;
      data_addr_i  = 32'h0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_wdata_i = 32'h0;
      wb_dat_i     = 32'h0;
      wb_ack_i     = 1'b0;
      wb_err_i     = 1'b0;

      // reset state; grant masked while in reset
      step();
      step();
      chk("rst_gnt",    {31'h0, data_gnt_o},    32'h0);
      chk("rst_cyc",    {31'h0, wb_cyc_o},      32'h0);
      chk("rst_rvalid", {31'h0, data_rvalid_o}, 32'h0);
      chk("rst_adr",    wb_adr_o,               32'h0);
      chk("rst_rdata",  data_rdata_o,           32'h0);
      rst_i      = 1'b0;
      data_req_i = 1'b0;
      step();

      // read, zero-wait
      request(32'h3000_0006, 1'b0, 4'b1100, 32'h0);
      #1;
      chk("rd_gnt", {31'h0, data_gnt_o}, 32'h1);
      step();
      data_req_i = 1'b0;
      chk("rd_stb", {31'h0, wb_stb_o}, 32'h1);
      chk("rd_adr", wb_adr_o, 32'h3000_0004);
      chk("rd_sel", {28'h0, wb_sel_o}, 32'hC);
      chk("rd_we",  {31'h0, wb_we_o}, 32'h0);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hDEAD_BEEF;
      step();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      chk("rd_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      chk("rd_rdata",  data_rdata_o, 32'hDEAD_BEEF);
      chk("rd_err",    {31'h0, data_err_o}, 32'h0);
      chk("rd_cyc_off", {31'h0, wb_cyc_o}, 32'h0);
      step();
      chk("rd_pulse", {31'h0, data_rvalid_o}, 32'h0);
      chk("rd_hold",  data_rdata_o, 32'hDEAD_BEEF);

      // write with 3 wait states
      request(32'h1000_0000, 1'b1, 4'hF, 32'h1234_5678);
      #1;
      chk("wr_gnt", {31'h0, data_gnt_o}, 32'h1);
      step();
      data_req_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wr_cyc_held", {31'h0, wb_cyc_o}, 32'h1);
         chk("wr_we_held",  {31'h0, wb_we_o},  32'h1);
         chk("wr_dat_held", wb_dat_o, 32'h1234_5678);
         chk("wr_no_rvalid", {31'h0, data_rvalid_o}, 32'h0);
         if (i == 3) wb_ack_i = 1'b1;
         step();
      end
      wb_ack_i = 1'b0;
      chk("wr_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      chk("wr_err",    {31'h0, data_err_o}, 32'h0);
      chk("wr_rdata",  data_rdata_o, 32'h0);
      chk("wr_cyc_off", {31'h0, wb_cyc_o}, 32'h0);
      step();
      chk("wr_pulse", {31'h0, data_rvalid_o}, 32'h0);

      // spurious ack/err in IDLE
      wb_ack_i = 1'b1;
      wb_err_i = 1'b1;
      step();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      chk("spur_cyc",    {31'h0, wb_cyc_o}, 32'h0);
      chk("spur_rvalid", {31'h0, data_rvalid_o}, 32'h0);
      step();
      chk("spur_rvalid2", {31'h0, data_rvalid_o}, 32'h0);

      // back-to-back reads
      request(32'h2000_0000, 1'b0, 4'hF, 32'h0);
      step();
      chk("b2b_gnt_bus", {31'h0, data_gnt_o}, 32'h0);
      data_addr_i = 32'h2000_0004;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h1111_1111;
      step();
      wb_ack_i = 1'b0;
      chk("b2b_rvalid1", {31'h0, data_rvalid_o}, 32'h1);
      chk("b2b_rdata1",  data_rdata_o, 32'h1111_1111);
      chk("b2b_gnt2",    {31'h0, data_gnt_o}, 32'h1);
      step();
      data_req_i = 1'b0;
      chk("b2b_stb2",    {31'h0, wb_stb_o}, 32'h1);
      chk("b2b_adr2",    wb_adr_o, 32'h2000_0004);
      chk("b2b_rv_gap",  {31'h0, data_rvalid_o}, 32'h0);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h2222_2222;
      step();
      wb_ack_i = 1'b0;
      chk("b2b_rvalid2", {31'h0, data_rvalid_o}, 32'h1);
      chk("b2b_rdata2",  data_rdata_o, 32'h2222_2222);
      step();
      chk("b2b_pulse", {31'h0, data_rvalid_o}, 32'h0);

      // ack and err together on a read
      request(32'h4000_0008, 1'b0, 4'hF, 32'h0);
      step();
      data_req_i = 1'b0;
      wb_ack_i = 1'b1;
      wb_err_i = 1'b1;
      wb_dat_i = 32'hCAFE_F00D;
      step();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      chk("err_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      chk("err_err",    {31'h0, data_err_o}, 32'h1);
      chk("err_rdata",  data_rdata_o, 32'h0);
      chk("err_cyc",    {31'h0, wb_cyc_o}, 32'h0);
      step();
      chk("err_hold",   {31'h0, data_err_o}, 32'h1);

      // reset mid-BUS
      request(32'h5000_0000, 1'b1, 4'hF, 32'hAAAA_5555);
      step();
      data_req_i = 1'b0;
      chk("rstbus_stb", {31'h0, wb_stb_o}, 32'h1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rstbus_cyc",    {31'h0, wb_cyc_o}, 32'h0);
      chk("rstbus_stb0",   {31'h0, wb_stb_o}, 32'h0);
      chk("rstbus_rvalid", {31'h0, data_rvalid_o}, 32'h0);
      step();
      chk("rstbus_rvalid2", {31'h0, data_rvalid_o}, 32'h0);
      request(32'h5000_000C, 1'b0, 4'h3, 32'h0);
      step();
      data_req_i = 1'b0;
      chk("post_rst_adr", wb_adr_o, 32'h5000_000C);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h0BAD_CAFE;
      step();
      wb_ack_i = 1'b0;
      chk("post_rst_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      chk("post_rst_rdata",  data_rdata_o, 32'h0BAD_CAFE);
      chk("post_rst_err",    {31'h0, data_err_o}, 32'h0);
      step();

      // unresponsive slave
      request(32'h6000_0000, 1'b0, 4'hF, 32'h0);
      step();
      data_req_i = 1'b0;
      hi_cnt = 0;
`ifdef IBEX_OBI_WB_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         if (wb_cyc_o === 1'b1) hi_cnt++;
         step();
      end
      chk("tmo_cyc_cycles", hi_cnt, 32'd4);
      chk("tmo_cyc_off",    {31'h0, wb_cyc_o}, 32'h0);
      chk("tmo_rvalid",     {31'h0, data_rvalid_o}, 32'h1);
      chk("tmo_err",        {31'h0, data_err_o}, 32'h1);
      chk("tmo_rdata",      data_rdata_o, 32'h0);
      wb_ack_i = 1'b1;
      step();
      wb_ack_i = 1'b0;
      chk("tmo_late_rvalid", {31'h0, data_rvalid_o}, 32'h0);
      chk("tmo_late_cyc",    {31'h0, wb_cyc_o}, 32'h0);
      step();
      chk("tmo_late_rvalid2", {31'h0, data_rvalid_o}, 32'h0);
`else
      for (int i = 0; i < 100; i++) begin
         if (wb_stb_o === 1'b1 && data_rvalid_o === 1'b0) hi_cnt++;
         step();
      end
      chk("notmo_stb_cycles", hi_cnt, 32'd100);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h7777_0000;
      step();
      wb_ack_i = 1'b0;
      chk("notmo_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      chk("notmo_err",    {31'h0, data_err_o}, 32'h0);
      chk("notmo_rdata",  data_rdata_o, 32'h7777_0000);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibex_obi_wb_bridge.md
Name: ibex_obi_wb_bridge

Overview:
- Downstream neighbour of the Ibex load/store unit. Consumes the LSU's data-side req/gnt/rvalid (OBI-style) port and drives a classic single-master Wishbone B4 bus, as used by the management SoC.
- Supports one outstanding transaction. The response is returned as a one-cycle rvalid pulse carrying read data or a bus error.
- A new request may be granted in the same cycle as rvalid, so back-to-back and misaligned-split LSU accesses are supported.

Parameters:
- TIMEOUT_CYCLES, 255: Wishbone cycles to wait for ack/err before forcing an error response. Range 1..65535. Used only when IBEX_OBI_WB_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- data_req_i  in  1  LSU request
- data_gnt_o  out  1  request accepted (combinational)
- data_rvalid_o  out  1  response valid, one-cycle pulse
- data_err_o  out  1  response is an error; qualified by data_rvalid_o
- data_addr_i  in  32  byte address (LSU sends word-aligned)
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  store data (already lane-aligned)
- data_rdata_o  out  32  load data; qualified by data_rvalid_o
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_adr_o  out  32  Wishbone address, bits [1:0] forced 0
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high (rst_i). All state updates on the rising edge of clk_i.
- States: IDLE, BUS, RESP.
- Reset values: state IDLE; wb_cyc_o = wb_stb_o = wb_we_o = 0; wb_sel_o = 0; wb_adr_o = 0; wb_dat_o = 0; data_rvalid_o = 0; data_err_o = 0; data_rdata_o = 0; timeout counter = 0.
- data_gnt_o = data_req_i & (state == IDLE | state == RESP) & ~rst_i.
- On grant:
  - Register wb_adr_o = {data_addr_i[31:2], 2'b00}, wb_we_o = data_we_i, wb_sel_o = data_be_i, wb_dat_o = data_wdata_i.
  - Next state BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; they are registered outputs, high from the cycle after grant.
  - Address, data, sel and we are held stable until the bus terminates.
  - wb_ack_i | wb_err_i ends the cycle. Next cycle: cyc/stb = 0, state RESP.
  - data_err_o <= wb_err_i. If ack and err are both high, err wins.
  - data_rdata_o <= wb_dat_i for a read with ack and no err; otherwise data_rdata_o <= 0.
- RESP:
  - data_rvalid_o = 1 for exactly this cycle.
  - If a grant occurs this cycle, next state BUS; otherwise IDLE.
  - data_rdata_o and data_err_o hold until the next response.
- Minimum latency: grant at cycle T, stb at T+1, earliest ack at T+1, rvalid at T+2. Back-to-back throughput is one transaction per 2 cycles with zero-wait slaves.
- wb_ack_i / wb_err_i in IDLE or RESP (spurious) are ignored, with no state change.
- data_req_i deasserted without grant: no effect. No request-abort path exists.
- Reset mid-BUS: cyc/stb drop on the next edge, the transaction is discarded, and no rvalid is issued.
- Ordering: exactly one rvalid per grant, in order.

Optional Feature:
- Macro: IBEX_OBI_WB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and increments each BUS cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES, cyc/stb drop, state goes to RESP with data_err_o = 1 and data_rdata_o = 0.
  - A late ack/err after the timeout is ignored.
  - ack arriving in the same cycle the counter hits the limit wins over the timeout.
- Not defined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- Read, zero-wait: req @0x3000_0006, we = 0, be = 4'b1100; ack with dat = 0xDEAD_BEEF one cycle after stb -> gnt same cycle; wb_adr_o = 0x3000_0004, sel = 4'b1100; rvalid 2 cycles after gnt; rdata = 0xDEAD_BEEF; err = 0.
- Write with 3 wait states: req @0x1000_0000, we = 1, be = 4'hF, wdata = 0x1234_5678 -> cyc/stb/we/dat held 4 cycles; one rvalid; err = 0; rdata = 0.
- Back-to-back: req held high for two accesses, ack immediate -> second gnt coincides with first rvalid; second stb the following cycle; two rvalids, in order.
- Bus error: ack and err asserted together on a read -> rvalid with err = 1, rdata = 0; cyc deasserted the next cycle.
- Reset mid-BUS: rst_i high for 1 cycle while stb is high -> cyc/stb = 0 after the edge; no rvalid; the next request works normally.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): no ack -> cyc drops after 4 BUS cycles; rvalid with err = 1; a later ack is ignored. Without the macro, the same stimulus keeps stb high for 100 cycles.
